// File: rtl/negate_pipe.sv
// Two-stage valid/ready pipeline computing a, -a, |a| or -|a| with an overflow flag and a
// saturating overflow event counter. Define NEGATE_PIPE_SAT_EN to clamp overflows to max positive.
module negate_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  typedef enum logic [1:0] {
    ModePass = 2'b00,
    ModeNeg  = 2'b01,
    ModeAbs  = 2'b10,
    ModeNabs = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_inv_q, s1_inv_d;
  logic             s1_neg_q, s1_neg_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_adv;
  logic             in_fire;
  logic             neg;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    in_ready = rst_n && (!s1_valid_q || s2_adv);
    in_fire  = in_valid && in_ready;

    unique case (mode_e'(in_mode))
      ModePass: neg = 1'b0;
      ModeNeg:  neg = 1'b1;
      ModeAbs:  neg = in_data[WIDTH-1];
      ModeNabs: neg = !in_data[WIDTH-1] && (in_data != '0);
      default:  neg = 1'b0;
    endcase

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_mode_d  = s1_mode_q;
    s1_inv_d   = s1_inv_q;
    s1_neg_d   = s1_neg_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_a_d    = in_data;
      s1_mode_d = mode_e'(in_mode);
      s1_inv_d  = neg ? ~in_data : in_data;
      s1_neg_d  = neg;
    end

    // Only -MinNeg is unrepresentable; both negate and abs can hit it.
    sum = s1_inv_q + {{(WIDTH-1){1'b0}}, s1_neg_q};
    ovf = ((s1_mode_q == ModeNeg) || (s1_mode_q == ModeAbs)) && (s1_a_q == MinNeg);

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
`ifdef NEGATE_PIPE_SAT_EN
        s2_data_d = ovf ? MaxPos : sum;
`else
        s2_data_d = sum;
`endif
        s2_ovf_d  = ovf;
      end
    end

    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && s2_ovf_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_mode_q  <= ModePass;
      s1_inv_q   <= '0;
      s1_neg_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_mode_q  <= s1_mode_d;
      s1_inv_q   <= s1_inv_d;
      s1_neg_q   <= s1_neg_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_ovf   = s2_ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: doc/negate_pipe.md
NEGATE_PIPE -- requirements
Module: negate_pipe

Interface
REQ-001 Parameter: WIDTH, default 4, data width in bits (two's complement); legal range 2..64.
REQ-002 Parameter: CNT_W, default 8, width of the overflow event counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  input beat present.
REQ-006 Port: in_ready  output  1  block can accept an input beat this cycle.
REQ-007 Port: in_data  input  WIDTH  operand a, two's complement.
REQ-008 Port: in_mode  input  2  operation: 00 pass, 01 negate (-a), 10 absolute (|a|), 11 negative-absolute (-|a|).
REQ-009 Port: out_valid  output  1  result beat present.
REQ-010 Port: out_ready  input  1  downstream accepts the result beat.
REQ-011 Port: out_data  output  WIDTH  result.
REQ-012 Port: out_ovf  output  1  result not representable in WIDTH bits; travels with out_data.
REQ-013 Port: ovf_cnt  output  CNT_W  saturating count of accepted beats whose result overflowed.
REQ-014 Port: ovf_clr  input  1  synchronous clear of ovf_cnt.

Function
REQ-015 Beat transfer at input SHALL occur on a rising edge where in_valid and in_ready are both 1; at output where out_valid and out_ready are both 1.
REQ-016 Two register stages SHALL be used: S1 captures operand, mode and a conditional-invert result; S2 adds the +1 carry and computes out_ovf.
REQ-017 Negation SHALL be bitwise inversion plus one, modulo 2^WIDTH.
REQ-018 Absolute mode SHALL negate only when a[WIDTH-1]=1; negative-absolute mode SHALL negate only when a[WIDTH-1]=0 and a is non-zero.
REQ-019 out_ovf SHALL be 1 only when mode is 01 or 10 and a equals the most-negative value (1 followed by WIDTH-1 zeros); pass and negative-absolute never overflow.
REQ-020 Latency SHALL be 2: a beat accepted on edge k is on out_* after edge k+1 when no stall occurs.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1; no bubbles inserted.
REQ-022 S2 SHALL load when empty or when its beat transfers out; S1 SHALL advance into S2 under the same condition.
REQ-023 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; with out_ready held 0 exactly two beats are held and in_ready falls.
REQ-024 out_data, out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Beat order SHALL be preserved; no beat dropped or duplicated under any valid/ready pattern.
REQ-026 ovf_cnt SHALL increment by one when an overflowing beat transfers out, saturating at 2^CNT_W-1.
REQ-027 ovf_clr SHALL clear ovf_cnt to 0 on the next edge and takes priority over a simultaneous increment.
REQ-028 in_data/in_mode SHALL be ignored when in_valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately clear S1/S2 valid flags, out_valid=0, out_ovf=0, out_data=0, ovf_cnt=0, independent of clk.
REQ-030 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; none appear after release.

Configuration
REQ-032 Macro NEGATE_PIPE_SAT_EN defined: an overflowing result SHALL be replaced by the most-positive value (0 followed by WIDTH-1 ones), out_ovf still 1.
REQ-033 Macro NEGATE_PIPE_SAT_EN undefined: an overflowing result SHALL be the modulo value (most-negative unchanged), out_ovf 1.

Verification
REQ-034 WIDTH=4, out_ready=1, mode 01, in_data 0011 -> out_data 1101, out_ovf 0, two edges after acceptance.
REQ-035 WIDTH=4, mode 01 and 10, in_data 1000 -> out_ovf 1, out_data 1000 (0111 with NEGATE_PIPE_SAT_EN), ovf_cnt +1 each.
REQ-036 WIDTH=4, modes 00/10/11 on in_data 1010 -> 1010, 0110, 1010; mode 11 on 0000 -> 0000.
REQ-037 Stream 0000..1111 mode 01, out_ready low for 3 cycles mid-stream -> in_ready low after 2 held, all 16 results in order, correct.
REQ-038 rst_n pulsed low with 2 beats in flight -> out_valid 0 at once, no stale beat after release; 300 overflow beats with CNT_W=8 -> ovf_cnt 255; ovf_clr -> 0.
